max_event_fifo: RTL

MAX_EVENT_FIFO -- requirements
Module: max_event_fifo

---
 rtl/max_event_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/max_event_fifo.sv
// Change detector on an upstream running maximum feeding a first-word-fall-through event FIFO.
// Optional macro MAX_EVENT_TIMESTAMP_EN builds the cycle counter and per-event timestamp storage.
module max_event_fifo #(
  parameter int data_width = 3,
  parameter int depth      = 4,
  parameter int ts_width   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [data_width-1:0]   max_in,
  input  logic                    event_ready,
  output logic                    event_valid,
  output logic [data_width-1:0]   event_data,
  output logic [ts_width-1:0]     event_time,
  output logic [$clog2(depth):0]  fifo_level,
  output logic [7:0]              drop_count
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(depth);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [data_width-1:0] prev_max;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [data_width-1:0] data_mem [depth];
  logic [AW:0]           level_nxt;
  logic                  is_event;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign is_event = (max_in != prev_max);
  assign full     = (fifo_level == FULL_LEVEL);
  assign pop      = event_valid && event_ready;
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign push     = is_event && (!full || pop);
  assign drop     = is_event && full && !pop;

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + (AW+1)'(1);
    else if (pop && !push)
      level_nxt = fifo_level - (AW+1)'(1);
  end

  // Control state: reference value, pointers, occupancy, drop statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_max    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      event_valid <= 1'b0;
      drop_count  <= '0;
    end else begin
      prev_max    <= max_in;
      fifo_level  <= level_nxt;
      event_valid <= (level_nxt != '0);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop)
        drop_count <= sat_inc(drop_count);
    end
  end

  // Storage is written only, never reset; the head is read straight out.
  always_ff @(posedge clock) begin
    if (push && !reset)
      data_mem[wr_ptr] <= max_in;
  end

  assign event_data = data_mem[rd_ptr];

`ifdef MAX_EVENT_TIMESTAMP_EN
  logic [ts_width-1:0] cycle_cnt;
  logic [ts_width-1:0] time_mem [depth];

  always_ff @(posedge clock) begin
    if (reset)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + ts_width'(1);
  end

  // The stored stamp is the count before this edge's increment.
  always_ff @(posedge clock) begin
    if (push && !reset)
      time_mem[wr_ptr] <= cycle_cnt;
  end

  assign event_time = time_mem[rd_ptr];
`else
  assign event_time = '0;
`endif

endmodule
